// File: rtl/step_sequencer_pkg.sv
// Shared encodings for the micro-step timing generator.
// Optional feature macro: STEP_SINGLE_EN (single-step advance via STEP).
package step_sequencer_pkg;

    typedef enum logic {
        SEQ_IDLE = 1'b0,
        SEQ_RUN  = 1'b1
    } seq_state_e;

    localparam logic [1:0] ENN_ON  = 2'b00;
    localparam logic [1:0] ENN_OFF = 2'b11;

    localparam logic [3:0] STEP_ZERO = 4'h0;
    localparam logic [3:0] STEP_MAX  = 4'hF;

endpackage

// File: rtl/step_counter_4b.sv
// 74HC161-style 4-bit counter: async clear, sync load, count enable,
// and a terminal-match output against a supplied last step.
module step_counter_4b
    import step_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       ld,
    input  logic [3:0] ld_val,
    input  logic       cen,
    input  logic [3:0] last,
    output logic [3:0] q,
    output logic       tc
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (ld) begin
            cnt_d = ld_val;
        end else if (cen) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_q <= STEP_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q  = cnt_q;
    assign tc = (cnt_q == last);

endmodule

// File: rtl/step_sequencer.sv
// Instruction-cycle step sequencer driving a 4-to-16 strobe decoder.
// Optional feature macro: STEP_SINGLE_EN (adds the STEP port).
module step_sequencer
    import step_sequencer_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [3:0] LAST,
    input  logic       HOLD,
    input  logic       JMP,
    input  logic [3:0] JMP_STEP,
    input  logic       ABORT,
`ifdef STEP_SINGLE_EN
    input  logic       STEP,
`endif
    output logic [3:0] A,
    output logic [1:0] ENn,
    output logic       BUSY,
    output logic       DONE
);

    seq_state_e state_q, state_d;
    logic [3:0] last_q, last_d;
    logic [1:0] enn_q, enn_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic       cnt_ld;
    logic [3:0] cnt_ld_val;
    logic       cnt_cen;
    logic [3:0] cnt_q;
    logic       cnt_tc;
    logic       step_ok;

`ifdef STEP_SINGLE_EN
    assign step_ok = STEP;
`else
    assign step_ok = 1'b1;
`endif

    step_counter_4b u_cnt (
        .clk    (CLK),
        .clr    (RST),
        .ld     (cnt_ld),
        .ld_val (cnt_ld_val),
        .cen    (cnt_cen),
        .last   (last_q),
        .q      (cnt_q),
        .tc     (cnt_tc)
    );

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        enn_d      = enn_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        cnt_ld     = 1'b0;
        cnt_ld_val = STEP_ZERO;
        cnt_cen    = 1'b0;

        case (state_q)
            SEQ_IDLE: begin
                if (START) begin
                    state_d = SEQ_RUN;
                    last_d  = LAST;
                    enn_d   = ENN_ON;
                    busy_d  = 1'b1;
                    cnt_ld  = 1'b1;
                end
            end
            SEQ_RUN: begin
                if (ABORT) begin
                    state_d = SEQ_IDLE;
                    enn_d   = ENN_OFF;
                    busy_d  = 1'b0;
                    cnt_ld  = 1'b1;
                end else if (HOLD || !step_ok) begin
                    state_d = SEQ_RUN;
                end else if (JMP) begin
                    cnt_ld     = 1'b1;
                    cnt_ld_val = JMP_STEP;
                end else if (!cnt_tc) begin
                    // Past LAST after a jump: saturate at 15.
                    cnt_cen = (cnt_q != STEP_MAX);
                end else if (START) begin
                    last_d = LAST;
                    done_d = 1'b1;
                    cnt_ld = 1'b1;
                end else begin
                    state_d = SEQ_IDLE;
                    enn_d   = ENN_OFF;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_ld  = 1'b1;
                end
            end
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= SEQ_IDLE;
            last_q  <= STEP_ZERO;
            enn_q   <= ENN_OFF;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            enn_q   <= enn_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign A    = cnt_q;
    assign ENn  = enn_q;
    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Directed self-checking bench for step_sequencer.
// Build with +define+STEP_SINGLE_EN to also cover single-step mode.
module tb_step_sequencer;

    logic       CLK;
    logic       RST;
    logic       START;
    logic [3:0] LAST;
    logic       HOLD;
    logic       JMP;
    logic [3:0] JMP_STEP;
    logic       ABORT;
`ifdef STEP_SINGLE_EN
    logic       STEP;
`endif
    logic [3:0] A;
    logic [1:0] ENn;
    logic       BUSY;
    logic       DONE;

    int vectors;
    int errs;

    step_sequencer dut (
        .CLK      (CLK),
        .RST      (RST),
        .START    (START),
        .LAST     (LAST),
        .HOLD     (HOLD),
        .JMP      (JMP),
        .JMP_STEP (JMP_STEP),
        .ABORT    (ABORT),
`ifdef STEP_SINGLE_EN
        .STEP     (STEP),
`endif
        .A        (A),
        .ENn      (ENn),
        .BUSY     (BUSY),
        .DONE     (DONE)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] ea,
                       input logic [1:0] een, input logic eb,
                       input logic ed);
        logic [7:0] obs;
        logic [7:0] exp;
        obs = {A, ENn, BUSY, DONE};
        exp = {ea, een, eb, ed};
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got A=%h ENn=%b BUSY=%b DONE=%b, want A=%h ENn=%b BUSY=%b DONE=%b",
                   tag, A, ENn, BUSY, DONE, ea, een, eb, ed);
        end
    endtask

    initial begin
        vectors  = 0;
        errs     = 0;
        RST      = 1'b1;
        START    = 1'b0;
        LAST     = 4'd0;
        HOLD     = 1'b0;
        JMP      = 1'b0;
        JMP_STEP = 4'd0;
        ABORT    = 1'b0;
`ifdef STEP_SINGLE_EN
        STEP     = 1'b1;
`endif
        #1;
        chk("reset", 4'd0, 2'b11, 1'b0, 1'b0);
        #2 RST = 1'b0;
        tick();
        chk("idle", 4'd0, 2'b11, 1'b0, 1'b0);

        // Basic LAST=3 cycle
        START = 1'b1; LAST = 4'd3;
        tick();
        START = 1'b0; LAST = 4'd0;
        chk("l3_s0", 4'd0, 2'b00, 1'b1, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("l3_step", 4'(k), 2'b00, 1'b1, 1'b0);
        end
        tick();
        chk("l3_done", 4'd0, 2'b11, 1'b0, 1'b1);
        tick();
        chk("l3_idle", 4'd0, 2'b11, 1'b0, 1'b0);

        // HOLD at step 2 of LAST=5: A = 0,1,2,2,2,3,4,5
        START = 1'b1; LAST = 4'd5;
        tick();
        START = 1'b0;
        chk("h_s0", 4'd0, 2'b00, 1'b1, 1'b0);
        tick(); chk("h_s1", 4'd1, 2'b00, 1'b1, 1'b0);
        tick(); chk("h_s2", 4'd2, 2'b00, 1'b1, 1'b0);
        HOLD = 1'b1;
        tick(); chk("h_hold1", 4'd2, 2'b00, 1'b1, 1'b0);
        tick(); chk("h_hold2", 4'd2, 2'b00, 1'b1, 1'b0);
        HOLD = 1'b0;
        for (int k = 3; k <= 5; k++) begin
            tick();
            chk("h_step", 4'(k), 2'b00, 1'b1, 1'b0);
        end
        tick(); chk("h_done", 4'd0, 2'b11, 1'b0, 1'b1);
        tick(); chk("h_idle", 4'd0, 2'b11, 1'b0, 1'b0);

        // JMP forward: 0,1,6,7, done
        START = 1'b1; LAST = 4'd7;
        tick();
        START = 1'b0;
        chk("j_s0", 4'd0, 2'b00, 1'b1, 1'b0);
        tick(); chk("j_s1", 4'd1, 2'b00, 1'b1, 1'b0);
        JMP = 1'b1; JMP_STEP = 4'd6;
        tick(); chk("j_s6", 4'd6, 2'b00, 1'b1, 1'b0);
        JMP = 1'b0;
        tick(); chk("j_s7", 4'd7, 2'b00, 1'b1, 1'b0);
        tick(); chk("j_done", 4'd0, 2'b11, 1'b0, 1'b1);
        tick();

        // JMP on the final step overrides finish
        START = 1'b1; LAST = 4'd7;
        tick();
        START = 1'b0;
        for (int k = 1; k <= 7; k++) tick();
        chk("jl_s7", 4'd7, 2'b00, 1'b1, 1'b0);
        JMP = 1'b1; JMP_STEP = 4'd2;
        tick(); chk("jl_s2", 4'd2, 2'b00, 1'b1, 1'b0);
        JMP = 1'b0;
        tick(); chk("jl_s3", 4'd3, 2'b00, 1'b1, 1'b0);
        ABORT = 1'b1;
        tick(); chk("jl_abort", 4'd0, 2'b11, 1'b0, 1'b0);
        ABORT = 1'b0;
        tick();

        // Back-to-back with START held, LAST=2
        START = 1'b1; LAST = 4'd2;
        tick(); chk("bb_s0", 4'd0, 2'b00, 1'b1, 1'b0);
        tick(); chk("bb_s1", 4'd1, 2'b00, 1'b1, 1'b0);
        tick(); chk("bb_s2", 4'd2, 2'b00, 1'b1, 1'b0);
        tick(); chk("bb_r0", 4'd0, 2'b00, 1'b1, 1'b1);
        tick(); chk("bb_r1", 4'd1, 2'b00, 1'b1, 1'b0);
        tick(); chk("bb_r2", 4'd2, 2'b00, 1'b1, 1'b0);
        tick(); chk("bb_q0", 4'd0, 2'b00, 1'b1, 1'b1);
        START = 1'b0;
        tick(); chk("bb_q1", 4'd1, 2'b00, 1'b1, 1'b0);
        tick(); chk("bb_q2", 4'd2, 2'b00, 1'b1, 1'b0);
        tick(); chk("bb_done", 4'd0, 2'b11, 1'b0, 1'b1);
        tick();

        // ABORT at step 3 of LAST=9
        START = 1'b1; LAST = 4'd9;
        tick();
        START = 1'b0;
        for (int k = 1; k <= 3; k++) tick();
        chk("ab_s3", 4'd3, 2'b00, 1'b1, 1'b0);
        ABORT = 1'b1;
        tick(); chk("ab_idle", 4'd0, 2'b11, 1'b0, 1'b0);
        ABORT = 1'b0;
        tick(); chk("ab_nodone", 4'd0, 2'b11, 1'b0, 1'b0);

        // Async RST at step 4
        START = 1'b1; LAST = 4'd9;
        tick();
        START = 1'b0;
        for (int k = 1; k <= 4; k++) tick();
        chk("rs_s4", 4'd4, 2'b00, 1'b1, 1'b0);
        #2 RST = 1'b1;
        #1 chk("rs_async", 4'd0, 2'b11, 1'b0, 1'b0);
        #1 RST = 1'b0;
        tick(); chk("rs_idle", 4'd0, 2'b11, 1'b0, 1'b0);
        START = 1'b1; LAST = 4'd1;
        tick(); chk("rs_restart", 4'd0, 2'b00, 1'b1, 1'b0);
        START = 1'b0;
        tick(); chk("rs_s1", 4'd1, 2'b00, 1'b1, 1'b0);
        tick(); chk("rs_done", 4'd0, 2'b11, 1'b0, 1'b1);
        tick();

        // LAST=0: one-step cycle
        START = 1'b1; LAST = 4'd0;
        tick(); chk("z_s0", 4'd0, 2'b00, 1'b1, 1'b0);
        START = 1'b0;
        tick(); chk("z_done", 4'd0, 2'b11, 1'b0, 1'b1);
        tick();

        // Jump past LAST saturates at 15
        START = 1'b1; LAST = 4'd3;
        tick();
        START = 1'b0;
        JMP = 1'b1; JMP_STEP = 4'd13;
        tick(); chk("sat_13", 4'd13, 2'b00, 1'b1, 1'b0);
        JMP = 1'b0;
        tick(); chk("sat_14", 4'd14, 2'b00, 1'b1, 1'b0);
        tick(); chk("sat_15", 4'd15, 2'b00, 1'b1, 1'b0);
        tick(); chk("sat_hold", 4'd15, 2'b00, 1'b1, 1'b0);
        ABORT = 1'b1;
        tick(); chk("sat_abort", 4'd0, 2'b11, 1'b0, 1'b0);
        ABORT = 1'b0;
        tick();

        // Jump past LAST=15 finishes at 15
        START = 1'b1; LAST = 4'd15;
        tick();
        START = 1'b0;
        JMP = 1'b1; JMP_STEP = 4'd14;
        tick(); chk("l15_14", 4'd14, 2'b00, 1'b1, 1'b0);
        JMP = 1'b0;
        tick(); chk("l15_15", 4'd15, 2'b00, 1'b1, 1'b0);
        tick(); chk("l15_done", 4'd0, 2'b11, 1'b0, 1'b1);
        tick();

`ifdef STEP_SINGLE_EN
        // Single-step: STEP every third edge, LAST=1
        START = 1'b1; LAST = 4'd1; STEP = 1'b0;
        tick(); chk("ss_s0", 4'd0, 2'b00, 1'b1, 1'b0);
        START = 1'b0;
        tick(); chk("ss_w0a", 4'd0, 2'b00, 1'b1, 1'b0);
        tick(); chk("ss_w0b", 4'd0, 2'b00, 1'b1, 1'b0);
        STEP = 1'b1;
        tick(); chk("ss_s1", 4'd1, 2'b00, 1'b1, 1'b0);
        STEP = 1'b0;
        tick(); chk("ss_w1a", 4'd1, 2'b00, 1'b1, 1'b0);
        tick(); chk("ss_w1b", 4'd1, 2'b00, 1'b1, 1'b0);
        STEP = 1'b1;
        tick(); chk("ss_done", 4'd0, 2'b11, 1'b0, 1'b1);
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
